// File: rtl/uart_ctrl_pkg.sv
// Shared register map, bit positions and TX sequencer states for the UART bus controller.
package uart_ctrl_pkg;

    localparam logic [2:0] ADR_DATA   = 3'd4;
    localparam logic [2:0] ADR_STATUS = 3'd5;
    localparam logic [2:0] ADR_CTRL   = 3'd6;

    localparam int unsigned ST_OVR  = 3;
    localparam int unsigned ST_FERR = 4;

    localparam int unsigned CT_RXIE = 0;
    localparam int unsigned CT_TXIE = 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_LOAD  = 2'd1,
        TX_WAITB = 2'd2,
        TX_WAITD = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  rx_count;
        logic [2:0]  rsvd_lo;
        logic        ferr;
        logic        ovr;
        logic        txfull;
        logic        txdone;
        logic        rxne;
    } status_t;

endpackage

// File: rtl/uart_ctrl_sync_fifo.sv
// Synchronous FIFO with combinational head and same-cycle push+pop, also when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata_c,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop frees the slot the full-case push overwrites, so both may proceed.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata_c = r_mem[r_rptr];
    assign o_count   = r_count;

endmodule

// File: rtl/uart_ctrl.sv
// UART bus controller: register decode, RX/TX FIFOs, sticky flags, TX sequencer, flow control.
// Optional CTRL register and interrupt output enabled by defining UART_IRQ_EN.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned RX_DEPTH   = 8,
    parameter int unsigned TX_DEPTH   = 4,
    parameter int unsigned HOLD_LEVEL = RX_DEPTH - 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [2:0]  bus_adr,
    input  logic [7:0]  bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_ferr,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        rx_hold,
    output logic        irq
);
    localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;

    tx_state_e        r_state;
    tx_state_e        w_state_nxt;
    logic [31:0]      r_bus_rdata;
    logic             r_bus_ready;
    logic [7:0]       r_tx_data;
    logic             r_tx_start;
    logic             r_rx_hold;
    logic             r_ovr;
    logic             r_ferr;

    logic [7:0]       w_rx_head;
    logic [7:0]       w_tx_head;
    logic [RX_CW-1:0] w_rx_count;
    logic [TX_CW-1:0] w_tx_count;
    logic             w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic             w_adr_data, w_adr_status;
    logic             w_acc, w_stall, w_fire, w_rd, w_wr;
    logic             w_rx_pop, w_tx_push, w_tx_pop;
    logic             w_txdone;
    status_t          w_status;
    logic [31:0]      w_rdata;

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (rx_valid),
        .i_wdata   (rx_data),
        .i_pop     (w_rx_pop),
        .o_rdata_c (w_rx_head),
        .o_count   (w_rx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_tx_push),
        .i_wdata   (bus_wdata),
        .i_pop     (w_tx_pop),
        .o_rdata_c (w_tx_head),
        .o_count   (w_tx_count)
    );

    assign w_rx_full    = (w_rx_count == RX_CW'(RX_DEPTH));
    assign w_rx_empty   = (w_rx_count == '0);
    assign w_tx_full    = (w_tx_count == TX_CW'(TX_DEPTH));
    assign w_tx_empty   = (w_tx_count == '0);
    assign w_adr_data   = (bus_adr == ADR_DATA);
    assign w_adr_status = (bus_adr == ADR_STATUS);

    // One wait state; a DATA write into a full TX FIFO (pre-pop view) waits for a free slot.
    assign w_acc     = bus_sel && !r_bus_ready;
    assign w_stall   = w_acc && bus_we && w_adr_data && w_tx_full;
    assign w_fire    = w_acc && !w_stall;
    assign w_rd      = w_fire && !bus_we;
    assign w_wr      = w_fire && bus_we;
    assign w_rx_pop  = w_rd && w_adr_data && !w_rx_empty;
    assign w_tx_push = w_wr && w_adr_data;
    assign w_txdone  = w_tx_empty && (r_state == TX_IDLE) && !tx_busy;

`ifdef UART_IRQ_EN
    logic [1:0] r_ctrl;
    logic       r_irq;
    logic       w_adr_ctrl;

    assign w_adr_ctrl = (bus_adr == ADR_CTRL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && w_adr_ctrl) r_ctrl <= bus_wdata[1:0];
            r_irq <= (r_ctrl[CT_RXIE] && !w_rx_empty) || (r_ctrl[CT_TXIE] && w_txdone) ||
                     r_ovr || r_ferr;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_status          = '0;
        w_status.rx_count = 8'(w_rx_count);
        w_status.ferr     = r_ferr;
        w_status.ovr      = r_ovr;
        w_status.txfull   = w_tx_full;
        w_status.txdone   = w_txdone;
        w_status.rxne     = !w_rx_empty;
    end

    always_comb begin
        w_rdata = '0;
        if (w_adr_data && !w_rx_empty) w_rdata = {24'b0, w_rx_head};
        else if (w_adr_status)         w_rdata = w_status;
`ifdef UART_IRQ_EN
        else if (w_adr_ctrl)           w_rdata = {30'b0, r_ctrl};
`endif
    end

    // Bus response, sticky flags (set beats clear) and flow-control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_rdata <= '0;
            r_bus_ready <= 1'b0;
            r_ovr       <= 1'b0;
            r_ferr      <= 1'b0;
            r_rx_hold   <= 1'b0;
        end else begin
            r_bus_ready <= w_fire;
            r_bus_rdata <= w_rd ? w_rdata : 32'b0;
            if (rx_valid && w_rx_full && !w_rx_pop)            r_ovr <= 1'b1;
            else if (w_wr && w_adr_status && bus_wdata[ST_OVR]) r_ovr <= 1'b0;
            if (rx_valid && rx_ferr)                            r_ferr <= 1'b1;
            else if (w_wr && w_adr_status && bus_wdata[ST_FERR]) r_ferr <= 1'b0;
            r_rx_hold <= (w_rx_count >= RX_CW'(HOLD_LEVEL));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= TX_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        case (r_state)
            TX_IDLE:  if (!w_tx_empty && !tx_busy) w_state_nxt = TX_LOAD;
            TX_LOAD: begin
                w_tx_pop    = 1'b1;
                w_state_nxt = TX_WAITB;
            end
            TX_WAITB: if (tx_busy)  w_state_nxt = TX_WAITD;
            TX_WAITD: if (!tx_busy) w_state_nxt = TX_IDLE;
            default:  w_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
        end else begin
            r_tx_start <= w_tx_pop;
            if (w_tx_pop) r_tx_data <= w_tx_head;
        end
    end

    assign bus_rdata = r_bus_rdata;
    assign bus_ready = r_bus_ready;
    assign tx_data   = r_tx_data;
    assign tx_start  = r_tx_start;
    assign rx_hold   = r_rx_hold;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed self-checking bench for uart_ctrl with a small uart_tx busy model.
`timescale 1ns/1ps
module tb_uart_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_sel, bus_we;
    logic [2:0]  bus_adr;
    logic [7:0]  bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ferr;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        rx_hold;
    logic        irq;

    logic        busy_force = 1'b0;
    int          busy_len   = 3;
    int          busy_cnt   = 0;
    logic [7:0]  tx_log [$];
    logic        irq_seen   = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_ctrl dut (
        .clk(clk), .reset(reset),
        .bus_sel(bus_sel), .bus_we(bus_we), .bus_adr(bus_adr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_hold(rx_hold), .irq(irq)
    );

    always #5 clk = ~clk;

    assign tx_busy = busy_force | (busy_cnt != 0);

    always @(posedge clk) begin
        if (tx_start === 1'b1) begin
            busy_cnt <= busy_len;
            tx_log.push_back(tx_data);
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (irq !== 1'b0 && reset === 1'b0) irq_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_xfer(input string tag, input logic we, input logic [2:0] adr,
                            input logic [7:0] wd, output logic [31:0] rd, output int lat);
        @(negedge clk);
        bus_sel = 1'b1; bus_we = we; bus_adr = adr; bus_wdata = wd;
        lat = -1; rd = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus_ready) begin
                lat = i; rd = bus_rdata;
                break;
            end
        end
        bus_sel = 1'b0; bus_we = 1'b0;
        if (lat < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        bus_xfer(tag, 1'b0, adr, 8'h00, rd, lat);
        check(tag, rd, exp);
    endtask

    task automatic wr(input string tag, input logic [2:0] adr, input logic [7:0] wd);
        logic [31:0] rd;
        int lat;
        bus_xfer(tag, 1'b1, adr, wd, rd, lat);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic fe);
        rx_valid = 1'b1; rx_data = b; rx_ferr = fe;
        @(negedge clk);
        rx_valid = 1'b0; rx_ferr = 1'b0;
    endtask

    task automatic wait_starts(input int target);
        for (int i = 0; i < 300; i++) begin
            if (tx_log.size() >= target) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat;
        int base;
        logic seen;

        reset = 1'b1; bus_sel = 1'b0; bus_we = 1'b0; bus_adr = '0; bus_wdata = '0;
        rx_data = '0; rx_valid = 1'b0; rx_ferr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdata", bus_rdata, 32'h0);
        check("rst_ready", 32'(bus_ready), 32'h0);
        check("rst_txdata", 32'(tx_data), 32'h0);
        check("rst_txstart", 32'(tx_start), 32'h0);
        check("rst_rxhold", 32'(rx_hold), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        rd_chk("status_idle", 3'd5, 32'h0000_0002);

        // Echo
        rx_send(8'h05, 1'b0);
        rd_chk("echo_status", 3'd5, 32'h0000_0103);
        rd_chk("echo_data", 3'd4, 32'h0000_0005);
        rd_chk("echo_status_empty", 3'd5, 32'h0000_0002);
        wr("echo_w1", 3'd4, 8'h05);
        wr("echo_w2", 3'd4, 8'h05);
        wait_starts(2);
        check("echo_starts", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() >= 2) begin
            check("echo_byte0", 32'(tx_log[0]), 32'h05);
            check("echo_byte1", 32'(tx_log[1]), 32'h05);
        end
        check("echo_txdata", 32'(tx_data), 32'h05);
        repeat (10) @(negedge clk);
        rd_chk("echo_txdone", 3'd5, 32'h0000_0002);

        // Framing error and unmapped offsets
        rx_send(8'h66, 1'b1);
        rd_chk("ferr_status", 3'd5, 32'h0000_0113);
        wr("ferr_clr", 3'd5, 8'h10);
        rd_chk("ferr_cleared", 3'd5, 32'h0000_0103);
        rd_chk("ferr_data", 3'd4, 32'h0000_0066);
        wr("unmapped_w", 3'd0, 8'hFF);
        rd_chk("unmapped_r7", 3'd7, 32'h0);
        rd_chk("unmapped_r0", 3'd0, 32'h0);
        rd_chk("ctrl_reset", 3'd6, 32'h0);
        rd_chk("status_after_unmapped", 3'd5, 32'h0000_0002);

        // Overrun and rx_hold
        for (int i = 0; i < 9; i++) begin
            rx_valid = 1'b1; rx_data = 8'h10 + 8'(i);
            @(negedge clk);
            if (i == 5) check("hold_not_yet", 32'(rx_hold), 32'h0);
            if (i == 6) check("hold_rise", 32'(rx_hold), 32'h1);
        end
        rx_valid = 1'b0;
        rd_chk("ovr_status", 3'd5, 32'h0000_080B);
        check("ovr_hold", 32'(rx_hold), 32'h1);
        wr("ovr_clr", 3'd5, 8'h08);
        rd_chk("ovr_cleared", 3'd5, 32'h0000_0803);
        for (int i = 0; i < 8; i++) rd_chk("ovr_drain", 3'd4, 32'h10 + 32'(i));
        rd_chk("ovr_empty_read", 3'd4, 32'h0);
        rd_chk("ovr_status_empty", 3'd5, 32'h0000_0002);
        check("hold_fall", 32'(rx_hold), 32'h0);

        // TX stall
        busy_force = 1'b1;
        base = tx_log.size();
        for (int i = 0; i < 4; i++) begin
            bus_xfer("stall_w", 1'b1, 3'd4, 8'hA1 + 8'(i), rd, lat);
            check("stall_ack_lat", 32'(lat), 32'd1);
        end
        @(negedge clk);
        bus_sel = 1'b1; bus_we = 1'b1; bus_adr = 3'd4; bus_wdata = 8'hA5;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus_ready) seen = 1'b1;
        end
        check("stall_held", 32'(seen), 32'h0);
        check("stall_no_start", 32'(tx_log.size() - base), 32'd0);
        busy_force = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_ready) begin
                seen = 1'b1;
                break;
            end
        end
        bus_sel = 1'b0; bus_we = 1'b0;
        check("stall_acked", 32'(seen), 32'h1);
        check("stall_one_start", 32'(tx_log.size() - base), 32'd1);
        wait_starts(base + 5);
        check("stall_starts", 32'(tx_log.size() - base), 32'd5);
        if (tx_log.size() >= base + 5) begin
            check("stall_first", 32'(tx_log[base]), 32'hA1);
            check("stall_last", 32'(tx_log[base+4]), 32'hA5);
        end
        repeat (10) @(negedge clk);
        rd_chk("stall_done", 3'd5, 32'h0000_0002);

        // Simultaneous push and pop
        rx_send(8'h31, 1'b0);
        rx_send(8'h32, 1'b0);
        rx_send(8'h33, 1'b0);
        @(negedge clk);
        bus_sel = 1'b1; bus_we = 1'b0; bus_adr = 3'd4;
        rx_valid = 1'b1; rx_data = 8'h34;
        @(negedge clk);
        check("simul_ready", 32'(bus_ready), 32'h1);
        check("simul_rdata", bus_rdata, 32'h31);
        bus_sel = 1'b0; rx_valid = 1'b0;
        rd_chk("simul_status", 3'd5, 32'h0000_0303);
        rd_chk("simul_d1", 3'd4, 32'h32);
        rd_chk("simul_d2", 3'd4, 32'h33);
        rd_chk("simul_d3", 3'd4, 32'h34);

        // Reset mid-frame
        busy_len = 30;
        base = tx_log.size();
        wr("mid_w1", 3'd4, 8'hC1);
        wr("mid_w2", 3'd4, 8'hC2);
        wr("mid_w3", 3'd4, 8'hC3);
        for (int i = 0; i < 50; i++) begin
            if (tx_busy) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("mid_one_start", 32'(tx_log.size() - base), 32'd1);
        rd_chk("mid_status", 3'd5, 32'h0000_0000);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rdata", bus_rdata, 32'h0);
        check("mid_ready", 32'(bus_ready), 32'h0);
        check("mid_txdata", 32'(tx_data), 32'h0);
        check("mid_txstart", 32'(tx_start), 32'h0);
        check("mid_hold_irq", {30'b0, rx_hold, irq}, 32'h0);
        reset = 1'b0;
        busy_len = 3;
        repeat (40) @(negedge clk);
        check("mid_no_restart", 32'(tx_log.size() - base), 32'd1);
        rd_chk("mid_status_after", 3'd5, 32'h0000_0002);

`ifdef UART_IRQ_EN
        wr("irq_ctrl", 3'd6, 8'h01);
        rd_chk("irq_ctrl_rd", 3'd6, 32'h1);
        check("irq_low", 32'(irq), 32'h0);
        rx_send(8'h50, 1'b0);
        repeat (2) @(negedge clk);
        check("irq_high", 32'(irq), 32'h1);
        rd_chk("irq_data", 3'd4, 32'h50);
        repeat (2) @(negedge clk);
        check("irq_cleared", 32'(irq), 32'h0);
`else
        rx_send(8'h50, 1'b0);
        repeat (2) @(negedge clk);
        check("irq_tied", 32'(irq), 32'h0);
        wr("irq_ctrl", 3'd6, 8'h01);
        rd_chk("irq_ctrl_rd", 3'd6, 32'h0);
        rd_chk("irq_data", 3'd4, 32'h50);
        check("irq_never", 32'(irq_seen), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
